// File: rtl/vga_pkg.sv
// Shared VGA definitions: pixel layout, default line depth and the bank state encoding.
package vga_pkg;

    localparam int PIX_W      = 12;
    localparam int COLOUR_W   = 4;
    localparam int RED_LSB    = 0;
    localparam int GREEN_LSB  = 4;
    localparam int BLUE_LSB   = 8;
    localparam int LINE_DEPTH = 640;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

endpackage

// File: rtl/vga_line_bank.sv
// One line bank: register array with a synchronous write port and an asynchronous read port.
module vga_line_bank #(
    parameter int PIX_W  = vga_pkg::PIX_W,
    parameter int DEPTH  = vga_pkg::LINE_DEPTH,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [PIX_W-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [PIX_W-1:0]  rdata
);

    logic [PIX_W-1:0] mem [DEPTH];

    // No reset on the array: the owner's full flags decide whether contents are meaningful.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vga_line_pingpong.sv
// Ping-pong pixel line buffer between the framebuffer fetch engine and the VGA timing controller.
// Optional underrun statistics counter enabled with `define VGA_LINE_PINGPONG_STATS_EN.
module vga_line_pingpong #(
    parameter int PIX_W      = vga_pkg::PIX_W,
    parameter int LINE_DEPTH = vga_pkg::LINE_DEPTH,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              en_i,
    input  logic [ADDR_W-1:0] line_len_i,
    input  logic              wr_valid_i,
    input  logic [PIX_W-1:0]  wr_data_i,
    output logic              wr_ready_o,
    input  logic              rd_req_i,
    output logic [PIX_W-1:0]  rd_data_o,
    output logic [1:0]        full_cnt_o,
    output logic              underrun_o,
    input  logic              clr_i
`ifdef VGA_LINE_PINGPONG_STATS_EN
    ,
    output logic [15:0]       underrun_cnt_o
`endif
);

    import vga_pkg::*;

    bank_state_t       state_q [2];
    bank_state_t       state_d [2];
    logic [1:0]        full;
    logic [1:0]        full_d;
    logic              wr_bank;
    logic              rd_bank;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] last_idx;
    logic [PIX_W-1:0]  bank_rdata [2];
    logic              wr_fire;
    logic              rd_fire;
    logic              underrun_evt;

    // Effective line length minus one: 0 behaves as a one-pixel line, oversize clamps to the bank depth.
    always_comb begin
        last_idx = '0;
        if (line_len_i == '0) begin
            last_idx = '0;
        end else if (line_len_i > ADDR_W'(LINE_DEPTH)) begin
            last_idx = ADDR_W'(LINE_DEPTH - 1);
        end else begin
            last_idx = line_len_i - ADDR_W'(1);
        end
    end

    assign wr_fire      = wr_valid_i & wr_ready_o;
    assign rd_fire      = rd_req_i & full[rd_bank];
    assign underrun_evt = rd_req_i & ~full[rd_bank];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        vga_line_bank #(
            .PIX_W (PIX_W),
            .DEPTH (LINE_DEPTH),
            .ADDR_W(ADDR_W)
        ) u_bank (
            .clk  (clk),
            .we   (wr_fire && (wr_bank == 1'(b))),
            .waddr(wr_ptr),
            .wdata(wr_data_i),
            .raddr(rd_ptr),
            .rdata(bank_rdata[b])
        );
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q[0] <= EMPTY;
            state_q[1] <= EMPTY;
        end else begin
            state_q[0] <= state_d[0];
            state_q[1] <= state_d[1];
        end
    end

    // The writer and reader never own the same bank while it is full, so both updates can apply.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            if (!en_i) begin
                state_d[b] = EMPTY;
            end else begin
                if (wr_fire && (wr_bank == 1'(b))) begin
                    state_d[b] = (wr_ptr == last_idx) ? FULL : FILLING;
                end
                if (rd_fire && (rd_bank == 1'(b)) && (rd_ptr == last_idx)) begin
                    state_d[b] = EMPTY;
                end
            end
        end
    end

    always_comb begin
        full       = '0;
        full_d     = '0;
        wr_ready_o = 1'b0;
        rd_data_o  = '0;
        for (int b = 0; b < 2; b++) begin
            full[b]   = (state_q[b] == FULL);
            full_d[b] = (state_d[b] == FULL);
        end
        wr_ready_o = en_i & ~full[wr_bank];
        if (full[rd_bank]) begin
            rd_data_o[RED_LSB   +: COLOUR_W] = bank_rdata[rd_bank][RED_LSB   +: COLOUR_W];
            rd_data_o[GREEN_LSB +: COLOUR_W] = bank_rdata[rd_bank][GREEN_LSB +: COLOUR_W];
            rd_data_o[BLUE_LSB  +: COLOUR_W] = bank_rdata[rd_bank][BLUE_LSB  +: COLOUR_W];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
            rd_ptr  <= '0;
            rd_bank <= 1'b0;
        end else if (!en_i) begin
            wr_ptr  <= '0;
            wr_bank <= 1'b0;
            rd_ptr  <= '0;
            rd_bank <= 1'b0;
        end else begin
            if (wr_fire) begin
                if (wr_ptr == last_idx) begin
                    wr_ptr  <= '0;
                    wr_bank <= ~wr_bank;
                end else begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                end
            end
            if (rd_fire) begin
                if (rd_ptr == last_idx) begin
                    rd_ptr  <= '0;
                    rd_bank <= ~rd_bank;
                end else begin
                    rd_ptr <= rd_ptr + ADDR_W'(1);
                end
            end
        end
    end

    // Count follows the next-state flags so it never lags the banks by a cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            full_cnt_o <= 2'd0;
        end else begin
            full_cnt_o <= {1'b0, full_d[0]} + {1'b0, full_d[1]};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            underrun_o <= 1'b0;
        end else if (underrun_evt) begin
            underrun_o <= 1'b1;
        end else if (clr_i) begin
            underrun_o <= 1'b0;
        end
    end

`ifdef VGA_LINE_PINGPONG_STATS_EN
    // Saturating underrun counter; a clear and an underrun together restart the count at one.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            underrun_cnt_o <= 16'd0;
        end else if (underrun_evt) begin
            if (clr_i) begin
                underrun_cnt_o <= 16'd1;
            end else if (underrun_cnt_o != 16'hFFFF) begin
                underrun_cnt_o <= underrun_cnt_o + 16'd1;
            end
        end else if (clr_i) begin
            underrun_cnt_o <= 16'd0;
        end
    end
`endif

endmodule
